// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: datapath width, reset/step defaults and the
// fetch FSM state encoding.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_out_buf.sv
// Single-entry valid/ready holding register carrying {instr, pc} to decode.
// A load takes precedence over flush; flush drops a held entry without a transfer.
module fetch_out_buf
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic            ready_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            fire_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_q;

    assign fire_o = valid_q && ready_i;

    always_comb begin
        valid_d = valid_q;
        if (load_i) begin
            valid_d = 1'b1;
        end else if (flush_i || fire_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_i) begin
                instr_q <= instr_i;
                pc_q    <= pc_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch stage: owns the PC, one outstanding imem request, redirect
// with stale-response drop. Optional perf counters under FETCH_PERF_CNT_EN.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic            req_q;
    logic            buf_load;
    logic            buf_flush;
    logic            buf_fire;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;

        unique case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        buf_load = 1'b1;
                        pc_d     = pc_q + PC_STEP;
                        state_d  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (buf_fire) begin
                    state_d = S_REQ;
                end
            end
        endcase

        // Redirect overrides everything above; an in-flight request that can
        // no longer be cancelled is marked so its response gets dropped.
        if (redirect_valid) begin
            pc_d      = redirect_pc;
            buf_load  = 1'b0;
            buf_flush = 1'b1;
            unique case (state_q)
                S_REQ: begin
                    drop_d  = 1'b1;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            req_q   <= (state_d == S_REQ);
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;

    fetch_out_buf u_out_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (buf_load),
        .flush_i (buf_flush),
        .ready_i (instr_ready),
        .instr_i (imem_rdata),
        .pc_i    (pc_q),
        .valid_o (instr_valid),
        .instr_o (instr),
        .pc_o    (instr_pc),
        .fire_o  (buf_fire)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (buf_fire) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state_q == S_WAIT) || ((state_q == S_HOLD) && !instr_ready)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with a fixed-latency
// instruction memory model; counter checks active under FETCH_PERF_CNT_EN.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    int          mem_cnt  = 0;
    int          mem_lat  = 2;
    logic [31:0] mem_data = 32'h0000_0013;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory answers mem_lat cycles after the request cycle with mem_data.
    always @(posedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt = mem_cnt - 1;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data;
            end
        end
        if (imem_req === 1'b1) mem_cnt = mem_lat;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        repeat (3) tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 0", instr); end
        total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (fetch_cnt !== 32'h0) begin bad++; $display("FAIL reset_fetch_cnt: got %h want 0", fetch_cnt); end
        total++; if (stall_cnt !== 32'h0) begin bad++; $display("FAIL reset_stall_cnt: got %h want 0", stall_cnt); end
`endif
    endtask

    task automatic test_sequential;
        int          nreq = 0;
        int          nval = 0;
        int          rc[8];
        logic [31:0] ra[8];
        int          vc[8];
        logic [31:0] vp[8];
        logic [31:0] vi[8];
        mem_data = 32'h0000_0013;
        rst_n = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            if (imem_req === 1'b1 && nreq < 8) begin rc[nreq] = c; ra[nreq] = imem_addr; nreq++; end
            if (instr_valid === 1'b1 && nval < 8) begin vc[nval] = c; vp[nval] = instr_pc; vi[nval] = instr; nval++; end
        end
        total++; if (nreq != 4) begin bad++; $display("FAIL seq_req_count: got %0d want 4", nreq); end
        total++; if (nval != 3) begin bad++; $display("FAIL seq_valid_count: got %0d want 3", nval); end
        for (int i = 0; i < nreq && i < 4; i++) begin
            total++; if (ra[i] !== 32'(4 * i)) begin bad++; $display("FAIL seq_req_addr[%0d]: got %h want %h", i, ra[i], 32'(4 * i)); end
            total++; if (rc[i] != 1 + 4 * i) begin bad++; $display("FAIL seq_req_cycle[%0d]: got %0d want %0d", i, rc[i], 1 + 4 * i); end
        end
        for (int i = 0; i < nval && i < 3; i++) begin
            total++; if (vp[i] !== 32'(4 * i)) begin bad++; $display("FAIL seq_instr_pc[%0d]: got %h want %h", i, vp[i], 32'(4 * i)); end
            total++; if (vi[i] !== 32'h0000_0013) begin bad++; $display("FAIL seq_instr[%0d]: got %h want 00000013", i, vi[i]); end
            total++; if (vc[i] != 4 + 4 * i) begin bad++; $display("FAIL seq_valid_cycle[%0d]: got %0d want %0d", i, vc[i], 4 + 4 * i); end
        end
    endtask

    task automatic test_backpressure;
        bit          ok;
        int          unstable = 0;
        int          reqs = 0;
        logic [31:0] i0, p0;
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] s0;
`endif
        instr_ready = 1'b0;
        wait_valid(ok);
        total++; if (!ok) begin bad++; $display("FAIL bp_wait_valid: got timeout want instr_valid"); end
        i0 = instr;
        p0 = instr_pc;
`ifdef FETCH_PERF_CNT_EN
        s0 = stall_cnt;
`endif
        total++; if (p0 !== 32'h0000_000C) begin bad++; $display("FAIL bp_instr_pc: got %h want 0000000c", p0); end
        for (int k = 0; k < 5; k++) begin
            tick();
            if (instr_valid !== 1'b1 || instr !== i0 || instr_pc !== p0) unstable++;
            if (imem_req !== 1'b0) reqs++;
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", unstable); end
        total++; if (reqs != 0) begin bad++; $display("FAIL bp_no_req: got %0d requests want 0", reqs); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (stall_cnt !== s0 + 32'd5) begin bad++; $display("FAIL bp_stall_cnt: got %h want %h", stall_cnt, s0 + 32'd5); end
`endif
        instr_ready = 1'b1;
        mem_data = 32'hDEAD_BEEF;
        tick();
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL bp_single_transfer: got valid=%b want 0", instr_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0010) begin bad++; $display("FAIL bp_next_req: got req=%b addr=%h want req=1 addr=00000010", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait;
        bit          ok;
        bit          got_req = 1'b0;
        bit          got_val = 1'b0;
        bit          dead = 1'b0;
        logic [31:0] req_addr = '0;
        logic [31:0] vpc = '0;
        logic [31:0] vins = '0;
        wait_req(ok);
        total++; if (!ok) begin bad++; $display("FAIL rw_wait_req: got timeout want imem_req"); end
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_addr !== 32'h0000_0100 || imem_req !== 1'b0) begin bad++; $display("FAIL rw_pc_loaded: got req=%b addr=%h want req=0 addr=00000100", imem_req, imem_addr); end
        mem_data = 32'h0000_0093;
        for (int k = 0; k < 12 && !got_val; k++) begin
            tick();
            if (imem_req === 1'b1 && !got_req) begin got_req = 1'b1; req_addr = imem_addr; end
            if (instr_valid === 1'b1) begin
                got_val = 1'b1; vpc = instr_pc; vins = instr;
                if (instr === 32'hDEAD_BEEF) dead = 1'b1;
            end
        end
        total++; if (dead) begin bad++; $display("FAIL rw_stale_word: got DEAD_BEEF presented want dropped"); end
        total++; if (!got_req || req_addr !== 32'h0000_0100) begin bad++; $display("FAIL rw_req_addr: got %h (seen=%b) want 00000100", req_addr, got_req); end
        total++; if (!got_val || vpc !== 32'h0000_0100) begin bad++; $display("FAIL rw_instr_pc: got %h (seen=%b) want 00000100", vpc, got_val); end
        total++; if (vins !== 32'h0000_0093) begin bad++; $display("FAIL rw_instr: got %h want 00000093", vins); end
    endtask

    task automatic test_redirect_rvalid;
        bit ok;
        mem_data = 32'hBAD0_0BAD;
        wait_req(ok);
        total++; if (!ok || imem_addr !== 32'h0000_0104) begin bad++; $display("FAIL rr_req: got ok=%b addr=%h want 00000104", ok, imem_addr); end
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        mem_data = 32'h0000_0113;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin bad++; $display("FAIL rr_next_req: got req=%b addr=%h want req=1 addr=00000200", imem_req, imem_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rr_dropped: got valid=%b want 0", instr_valid); end
        wait_valid(ok);
        total++; if (!ok || instr_pc !== 32'h0000_0200 || instr !== 32'h0000_0113) begin bad++; $display("FAIL rr_instr: got ok=%b pc=%h instr=%h want pc=00000200 instr=00000113", ok, instr_pc, instr); end
    endtask

    task automatic test_redirect_hold;
        bit ok;
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] f0;
`endif
        tick();
        instr_ready = 1'b0;
        wait_valid(ok);
        total++; if (!ok || instr_pc !== 32'h0000_0204) begin bad++; $display("FAIL rh_hold: got ok=%b pc=%h want 00000204", ok, instr_pc); end
`ifdef FETCH_PERF_CNT_EN
        f0 = fetch_cnt;
`endif
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rh_valid_clear: got %b want 0", instr_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0300) begin bad++; $display("FAIL rh_next_req: got req=%b addr=%h want req=1 addr=00000300", imem_req, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (fetch_cnt !== f0 + 32'd1) begin bad++; $display("FAIL rh_fetch_cnt: got %h want %h", fetch_cnt, f0 + 32'd1); end
`endif
        wait_valid(ok);
        total++; if (!ok || instr_pc !== 32'h0000_0300) begin bad++; $display("FAIL rh_instr_pc: got ok=%b pc=%h want 00000300", ok, instr_pc); end
    endtask

    task automatic test_wrap;
        bit ok;
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
        wait_valid(ok);
        total++; if (!ok || instr_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_instr_pc: got ok=%b pc=%h want fffffffc", ok, instr_pc); end
        wait_req(ok);
        total++; if (!ok || imem_addr !== 32'h0000_0000) begin bad++; $display("FAIL wrap_next_addr: got ok=%b addr=%h want 00000000", ok, imem_addr); end
    endtask

    task automatic test_reset_mid_wait;
        bit ok;
        tick();
        mem_data = 32'hBADB_AD00;
        rst_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL mr_ctrl: got req=%b valid=%b want 0 0", imem_req, instr_valid); end
        total++; if (instr !== 32'h0 || instr_pc !== 32'h0 || imem_addr !== 32'h0) begin bad++; $display("FAIL mr_data: got instr=%h pc=%h addr=%h want all 0", instr, instr_pc, imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        total++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin bad++; $display("FAIL mr_counters: got %h %h want 0 0", fetch_cnt, stall_cnt); end
`endif
        #1;
        rst_n = 1'b1;
        tick();
        mem_data = 32'h0000_0517;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0000) begin bad++; $display("FAIL mr_first_req: got req=%b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
        wait_valid(ok);
        total++; if (!ok || instr_pc !== 32'h0 || instr !== 32'h0000_0517) begin bad++; $display("FAIL mr_first_instr: got ok=%b pc=%h instr=%h want pc=00000000 instr=00000517", ok, instr_pc, instr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_hold();
        test_wrap();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Multi-cycle instruction fetch stage directly upstream of decode, register file and ALU.
- Owns the architectural PC.
- Issues one request at a time to a latency-variable instruction memory.
- Buffers the returned word and hands {instr, pc} to decode over a valid/ready handshake.
- Accepts a redirect (branch/jump target) at any time, discarding stale in-flight data.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- PC_STEP, 4: PC increment per sequential fetch.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  request strobe, one-cycle pulse per fetch.
- imem_addr  out  32  fetch address, valid when imem_req=1.
- imem_rvalid  in  1  memory response valid, one cycle.
- imem_rdata  in  32  instruction word, sampled when imem_rvalid=1.
- redirect_valid  in  1  load a new PC this cycle.
- redirect_pc  in  32  redirect target.
- instr_valid  out  1  instr/instr_pc hold a valid instruction.
- instr_ready  in  1  decode accepts this cycle.
- instr  out  32  buffered instruction word.
- instr_pc  out  32  address of the buffered instruction.

Behaviour:
- Registers: pc, state, out_instr, out_pc, drop flag.
- All outputs are registered except imem_addr, which equals pc.
- Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, imem_req=0, instr_valid=0, instr=0, instr_pc=0, drop=0.
- IDLE: go to REQ on the first clock after reset release.
- REQ:
  - imem_req=1, imem_addr=pc for exactly one cycle.
  - Next state WAIT.
- WAIT:
  - On imem_rvalid with drop=0: out_instr<=imem_rdata, out_pc<=pc, pc<=pc+PC_STEP, instr_valid<=1, next state HOLD.
  - On imem_rvalid with drop=1: discard the data, clear drop, next state REQ.
  - Without imem_rvalid: stay in WAIT (no timeout).
- HOLD:
  - instr_valid=1; instr and instr_pc stable until the transfer.
  - On instr_valid&&instr_ready: instr_valid<=0, next state REQ.
- Redirect (highest priority, any state except reset):
  - pc<=redirect_pc, and the next state is REQ.
  - Exception: in WAIT without imem_rvalid, stay in WAIT with drop<=1.
  - In HOLD: instr_valid<=0 next cycle. If instr_ready was also high that cycle, the transfer still counts as accepted.
  - In WAIT with imem_rvalid in the same cycle: the returned word is discarded and pc takes redirect_pc.
  - In REQ: the issued request becomes stale; drop<=1 and next state WAIT.
- Exactly one outstanding memory request at any time.
- Sustained throughput is one instruction per (memory latency + 2) cycles.
- PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
- Reset asserted mid-transaction: all state clears immediately. A late imem_rvalid arriving while in IDLE/REQ is ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0 and wrapping on overflow.
  - fetch_cnt increments on each accepted decode transfer.
  - stall_cnt increments each cycle in WAIT, or in HOLD with instr_ready=0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package riscv_pkg holds RESET_PC default, PC_STEP, the fetch state encoding (IDLE, REQ, WAIT, HOLD as 2-bit localparams) and the 32-bit XLEN width.
- One natural sub-module: fetch_out_buf, the single-entry valid/ready holding register for instr/instr_pc.
- The FSM and pc stay in the top module.

Test Plan:
- Reset release, memory returning 32'h0000_0013 two cycles after each req, instr_ready tied 1 -> first imem_req at addr 0, then 4, 8. instr_valid pulses with instr_pc 0,4,8. Request spacing is 4 cycles.
- Backpressure: instr_ready=0 for 5 cycles in HOLD -> instr and instr_pc stable, no imem_req issued. One transfer occurs when ready rises.
- Redirect to 32'h0000_0100 while in WAIT, response word 32'hDEAD_BEEF arriving later -> that word is never presented. The next imem_req is at 0x100, and instr_pc=0x100.
- Redirect coincident with imem_rvalid -> data dropped, pc=redirect_pc, the next request goes to the target.
- Redirect coincident with an accepted HOLD transfer -> fetch_cnt increments by 1 (macro on); the next fetch goes to the target.
- Wrap: redirect to 32'hFFFF_FFFC -> the following sequential fetch address is 32'h0000_0000.
- Async reset asserted mid-WAIT -> all outputs zero immediately; the first post-release fetch is at RESET_PC.
